antilog_conv: RTL

Log-to-linear (antilog) converter; the return path for log-domain values produced by the log/offset front end. Accepts a log value (integer characteristic plus fraction), applies Mitchell antilog 2^(k+f) ≈ 2^k·(1+f) with an optional per-segment correction, and emits a linear fixed-point magnitude. It is a 3-stage valid/ready pipeline feeding the PE accumulate path.

---
 rtl/antilog_pkg.sv | 20 ++
 rtl/lut_antilog_offset.sv | 13 +
 rtl/antilog_conv.sv | 123 ++++++++++++
 3 files changed

// File: rtl/antilog_pkg.sv
// Shared widths, types and the Mitchell correction table for the antilog converter.
// The table is consumed only when ANTILOG_CORR_EN is defined.
package antilog_pkg;

  localparam int unsigned INT_W  = 4;
  localparam int unsigned FRAC_W = 12;
  localparam int unsigned SEG_W  = 4;
  localparam int unsigned OUT_W  = FRAC_W + 1 + (2**INT_W - 1);

  typedef logic [FRAC_W:0]   mant_t;
  typedef logic [OUT_W-1:0]  out_t;
  typedef logic [FRAC_W-1:0] corr_t;

  // round(4096 * ((1 + i/16) - 2^(i/16))); the last entry is tuned to 90
  localparam corr_t CORR_TABLE [2**SEG_W] = '{
    12'd0,   12'd75,  12'd141, 12'd200, 12'd249, 12'd289, 12'd320, 12'd341,
    12'd351, 12'd351, 12'd339, 12'd315, 12'd279, 12'd230, 12'd168, 12'd90
  };

endpackage

// File: rtl/lut_antilog_offset.sv
// Segment index to Mitchell antilog correction offset (combinational lookup).
module lut_antilog_offset
  import antilog_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output corr_t            corr
);

  always_comb begin
    corr = CORR_TABLE[seg];
  end

endmodule

// File: rtl/antilog_conv.sv
// Log-to-linear converter: 3-stage valid/ready pipeline computing (1+f-corr) << k.
// Define ANTILOG_CORR_EN to subtract the per-segment correction; otherwise pure Mitchell.
module antilog_conv
  import antilog_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INT_W-1:0]  in_int,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_sign,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_mag,
  output logic              out_sign
);

  logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic [INT_W-1:0]  s1_int_q, s1_int_d, s2_int_q, s2_int_d;
  logic [FRAC_W-1:0] s1_frac_q, s1_frac_d;
  logic              s1_sign_q, s1_sign_d, s2_sign_q, s2_sign_d, s3_sign_q, s3_sign_d;
  logic              s1_zero_q, s1_zero_d, s2_zero_q, s2_zero_d;
  mant_t             s2_mant_q, s2_mant_d;
  out_t              s3_mag_q, s3_mag_d;
  logic              s1_rdy, s2_rdy, s3_rdy;
  mant_t             mant_calc;

`ifdef ANTILOG_CORR_EN
  corr_t corr;

  lut_antilog_offset u_lut (
    .seg  (s1_frac_q[FRAC_W-1 -: SEG_W]),
    .corr (corr)
  );

  always_comb begin
    mant_calc = mant_t'({1'b1, s1_frac_q}) - mant_t'(corr);
  end
`else
  always_comb begin
    mant_calc = {1'b1, s1_frac_q};
  end
`endif

  // A stage may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    s3_rdy   = !s3_v_q || out_ready;
    s2_rdy   = !s2_v_q || s3_rdy;
    s1_rdy   = !s1_v_q || s2_rdy;
    in_ready = s1_rdy;

    s1_v_d    = s1_rdy ? in_valid : s1_v_q;
    s1_int_d  = s1_int_q;
    s1_frac_d = s1_frac_q;
    s1_sign_d = s1_sign_q;
    s1_zero_d = s1_zero_q;
    if (s1_rdy && in_valid) begin
      s1_int_d  = in_int;
      s1_frac_d = in_frac;
      s1_sign_d = in_sign;
      s1_zero_d = in_zero;
    end

    s2_v_d    = s2_rdy ? s1_v_q : s2_v_q;
    s2_int_d  = s2_int_q;
    s2_mant_d = s2_mant_q;
    s2_sign_d = s2_sign_q;
    s2_zero_d = s2_zero_q;
    if (s2_rdy && s1_v_q) begin
      s2_int_d  = s1_int_q;
      s2_mant_d = mant_calc;
      s2_sign_d = s1_sign_q;
      s2_zero_d = s1_zero_q;
    end

    s3_v_d    = s3_rdy ? s2_v_q : s3_v_q;
    s3_mag_d  = s3_mag_q;
    s3_sign_d = s3_sign_q;
    if (s3_rdy && s2_v_q) begin
      s3_mag_d  = s2_zero_q ? '0 : (out_t'(s2_mant_q) << s2_int_q);
      s3_sign_d = s2_sign_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s3_v_q    <= 1'b0;
      s1_int_q  <= '0;
      s1_frac_q <= '0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s2_int_q  <= '0;
      s2_mant_q <= '0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s3_mag_q  <= '0;
      s3_sign_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      s3_v_q    <= s3_v_d;
      s1_int_q  <= s1_int_d;
      s1_frac_q <= s1_frac_d;
      s1_sign_q <= s1_sign_d;
      s1_zero_q <= s1_zero_d;
      s2_int_q  <= s2_int_d;
      s2_mant_q <= s2_mant_d;
      s2_sign_q <= s2_sign_d;
      s2_zero_q <= s2_zero_d;
      s3_mag_q  <= s3_mag_d;
      s3_sign_q <= s3_sign_d;
    end
  end

  assign out_valid = s3_v_q;
  assign out_mag   = s3_mag_q;
  assign out_sign  = s3_sign_q;

endmodule
